// File: rtl/sformat_int_stream.sv
// sformat_int_stream: integer-to-ASCII formatter (bin/oct/dec/hex).
// Converts one WIDTH-bit operand per request into a character string,
// most-significant character first, with $sformatf-style field padding
// or minimal-width output.
//
// Handshakes: a transfer happens on a rising clk edge when valid && ready
// are both high; valid, once raised, stays high with its payload held
// stable until that transfer, and ready may change freely.
module sformat_int_stream #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   input  logic [1:0]       in_mode,
   input  logic             in_signed,
   input  logic             in_pad,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             out_last,
   output logic [1:0]       dbg_state
);

   // Digit count of 2^w-1 equals floor(w*log10(2))+1 since 2^w is never a power of ten.
   function automatic int dec_digits(input int w);
      longint t;
      t = longint'(w) * 64'd301029995;
      return int'(t / 64'd1000000000) + 1;
   endfunction

   function automatic logic [7:0] to_ascii(input logic [3:0] d);
      return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
   endfunction

   localparam int BIN_W = WIDTH;
   localparam int OCT_W = (WIDTH + 2) / 3;
   localparam int HEX_W = (WIDTH + 3) / 4;
   localparam int DEC_W = dec_digits(WIDTH);
   localparam int CW    = $clog2(WIDTH + 1);
   // Remainder register is at least 8 bits so the 3/4-bit digit taps and the /10 are always legal.
   localparam int XW    = (WIDTH < 8) ? 8 : WIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_LOAD    = 2'd2,
      S_EMIT    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         mode_q;
   logic               pad_q, sgn_q, neg_q;
   logic [XW-1:0]      rem_q, next_rem;
   logic [CW-1:0]      cnt_q, sig_q, pos_q;
   logic [4*WIDTH-1:0] dig_buf;
   logic [3:0]         digit, cur_digit;
   logic [CW-1:0]      n_digits, len;
   logic               conv_last;
   logic               is_neg_in;
   logic [WIDTH-1:0]   mag;

   // Magnitude of the incoming operand; the most negative value maps to 2^(WIDTH-1).
   always_comb begin
      is_neg_in = (in_mode == 2'd2) && in_signed && in_value[WIDTH-1];
      mag       = is_neg_in ? (~in_value + 1'b1) : in_value;
   end

   // Next digit and remainder for the current base, plus digit count and string length.
   always_comb begin
      digit    = '0;
      next_rem = rem_q;
      n_digits = CW'(HEX_W);
      case (mode_q)
         2'd0: begin
            digit    = {3'b000, rem_q[0]};
            next_rem = rem_q >> 1;
            n_digits = CW'(BIN_W);
         end
         2'd1: begin
            digit    = {1'b0, rem_q[2:0]};
            next_rem = rem_q >> 3;
            n_digits = CW'(OCT_W);
         end
         2'd2: begin
            digit    = 4'(rem_q % XW'(10));
            next_rem = rem_q / XW'(10);
            n_digits = CW'(DEC_W);
         end
         default: begin
            digit    = rem_q[3:0];
            next_rem = rem_q >> 4;
            n_digits = CW'(HEX_W);
         end
      endcase
      conv_last = pad_q ? (cnt_q == n_digits - 1'b1) : (next_rem == '0);
      len       = (mode_q == 2'd2 && pad_q) ? (CW'(DEC_W) + CW'(sgn_q))
                                            : (cnt_q + CW'(neg_q));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (in_valid) state_d = S_CONVERT;
         S_CONVERT: if (conv_last) state_d = S_LOAD;
         S_LOAD:    state_d = S_EMIT;
         S_EMIT:    if (out_ready && pos_q == '0) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Datapath: latch request, build digits LSD first, then walk columns MSD first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= '0;
         pad_q   <= 1'b0;
         sgn_q   <= 1'b0;
         neg_q   <= 1'b0;
         rem_q   <= '0;
         cnt_q   <= '0;
         sig_q   <= '0;
         pos_q   <= '0;
         dig_buf <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  mode_q <= in_mode;
                  pad_q  <= in_pad;
                  sgn_q  <= in_signed && (in_mode == 2'd2);
                  neg_q  <= is_neg_in;
                  rem_q  <= XW'(mag);
                  cnt_q  <= '0;
                  sig_q  <= CW'(1);
               end
            end
            S_CONVERT: begin
               dig_buf[4*cnt_q +: 4] <= digit;
               rem_q                 <= next_rem;
               cnt_q                 <= cnt_q + 1'b1;
               if (digit != 4'd0) sig_q <= cnt_q + 1'b1;
            end
            S_LOAD: begin
               pos_q <= len - 1'b1;
            end
            S_EMIT: begin
               if (out_ready && pos_q != '0) pos_q <= pos_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs: column pos_q (0 = rightmost) is a digit, the sign, a pad space or a kept zero.
   always_comb begin
      cur_digit = dig_buf[4*pos_q +: 4];
      in_ready  = (state_q == S_IDLE) && !rst;
      out_valid = (state_q == S_EMIT);
      out_last  = (state_q == S_EMIT) && (pos_q == '0);
      out_char  = 8'h00;
      dbg_state = state_q;
      if (state_q == S_EMIT) begin
         if (pos_q < sig_q)                out_char = to_ascii(cur_digit);
         else if (pos_q == sig_q && neg_q) out_char = 8'h2d;
         else if (mode_q == 2'd2)          out_char = 8'h20;
         else                              out_char = to_ascii(cur_digit);
      end
   end

endmodule

// File: tb/tb_sformat_int_stream.sv
// Directed and randomised checks of sformat_int_stream at WIDTH=8 and WIDTH=32.
module tb_sformat_int_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_value = '0;
   logic [1:0]  in_mode = '0;
   logic        in_signed = 1'b0;
   logic        in_pad = 1'b0;
   logic        out_ready = 1'b1;
   logic        sel8 = 1'b0;

   logic       in_valid8, in_ready8, out_valid8, out_last8;
   logic [7:0] out_char8;
   logic [1:0] dbg8;
   logic       in_valid32, in_ready32, out_valid32, out_last32;
   logic [7:0] out_char32;
   logic [1:0] dbg32;

   logic       o_ready, o_valid, o_last;
   logic [7:0] o_char;

   int n_checks = 0;
   int n_pass   = 0;

   assign in_valid8  = in_valid & sel8;
   assign in_valid32 = in_valid & ~sel8;
   assign o_ready = sel8 ? in_ready8  : in_ready32;
   assign o_valid = sel8 ? out_valid8 : out_valid32;
   assign o_last  = sel8 ? out_last8  : out_last32;
   assign o_char  = sel8 ? out_char8  : out_char32;

   sformat_int_stream #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_value(in_value[7:0]), .in_mode(in_mode), .in_signed(in_signed), .in_pad(in_pad),
      .out_valid(out_valid8), .out_ready(out_ready), .out_char(out_char8),
      .out_last(out_last8), .dbg_state(dbg8)
   );

   sformat_int_stream #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .in_value(in_value), .in_mode(in_mode), .in_signed(in_signed), .in_pad(in_pad),
      .out_valid(out_valid32), .out_ready(out_ready), .out_char(out_char32),
      .out_last(out_last32), .dbg_state(dbg32)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference text for a WIDTH=32 operand.
   function automatic string exp32(input logic [1:0] mode, input bit sgn, input bit pad,
                                   input logic [31:0] v);
      string s;
      int    w;
      case (mode)
         2'd0: s = pad ? $sformatf("%b", v) : $sformatf("%0b", v);
         2'd1: s = pad ? $sformatf("%o", v) : $sformatf("%0o", v);
         2'd3: s = pad ? $sformatf("%x", v) : $sformatf("%0x", v);
         default: begin
            s = sgn ? $sformatf("%0d", $signed(v)) : $sformatf("%0d", v);
            w = sgn ? 11 : 10;
            if (pad) while (s.len() < w) s = {" ", s};
         end
      endcase
      return s;
   endfunction

   // Driver: issue one request and collect the string up to out_last.
   // thr: 0 = always ready, 1 = random throttle, 2 = stall 3 cycles on the 2nd char.
   task automatic send(input logic [1:0] mode, input bit sgn, input bit pad,
                       input logic [31:0] val, input int thr,
                       output string s, output int lat,
                       output bit bad_stable, output bit bad_ready);
      int         k;
      int         st;
      bit         done;
      bit         rdy;
      bit         hold_prev;
      logic [7:0] prev_c;
      logic       prev_l;
      s = ""; lat = -1; bad_stable = 0; bad_ready = 0;
      k = 0; st = 0; done = 0; hold_prev = 0; prev_c = '0; prev_l = 1'b0;
      @(negedge clk);
      in_mode = mode; in_signed = sgn; in_pad = pad; in_value = val; in_valid = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && o_ready !== 1'b1; i++) @(negedge clk);
      if (o_ready !== 1'b1) begin
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      while (!done && k < 400) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_value = $urandom;
         if (o_ready === 1'b1) bad_ready = 1;
         if (o_valid === 1'b1 && lat < 0) lat = k;
         if (hold_prev && (o_char !== prev_c || o_last !== prev_l)) bad_stable = 1;
         rdy = 1'b1;
         if (thr == 1) rdy = ($urandom_range(0, 3) != 0);
         else if (thr == 2 && s.len() == 1 && st < 3) begin
            rdy = 1'b0;
            st++;
         end
         out_ready = rdy;
         if (o_valid === 1'b1 && rdy) begin
            s = $sformatf("%s%c", s, o_char);
            if (o_last === 1'b1) done = 1;
         end
         hold_prev = (o_valid === 1'b1) && !rdy;
         prev_c = o_char;
         prev_l = o_last;
         @(posedge clk);
         k++;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready32 !== 1'b0) $display("FAIL reset_in_ready32: got %b want 0", in_ready32);
      else n_pass++;
      n_checks++;
      if (in_ready8 !== 1'b0) $display("FAIL reset_in_ready8: got %b want 0", in_ready8);
      else n_pass++;
      n_checks++;
      if (out_valid32 !== 1'b0 || out_last32 !== 1'b0 || out_char32 !== 8'h00)
         $display("FAIL reset_outputs: valid=%b last=%b char=%h want 0/0/00",
                  out_valid32, out_last32, out_char32);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready32 !== 1'b1 || in_ready8 !== 1'b1)
         $display("FAIL reset_release_ready: got %b/%b want 1/1", in_ready32, in_ready8);
      else n_pass++;
   endtask

   task automatic test_bin8;
      string s; int lat; bit bs, br;
      sel8 = 1'b1;
      send(2'd0, 1'b0, 1'b1, 32'd120, 0, s, lat, bs, br);
      n_checks++;
      if (s != "01111000") $display("FAIL bin8_120: got \"%s\" want \"01111000\"", s);
      else n_pass++;
      n_checks++;
      if (lat !== 9) $display("FAIL bin8_latency: got %0d want 9", lat);
      else n_pass++;
      n_checks++;
      if (br) $display("FAIL bin8_in_ready_busy: got in_ready=1 mid-string want 0");
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1)
         $display("FAIL bin8_after_last: valid=%b ready=%b want 0/1", o_valid, o_ready);
      else n_pass++;
   endtask

   task automatic test_pad32;
      string s; int lat; bit bs, br;
      sel8 = 1'b0;
      send(2'd1, 1'b0, 1'b1, 32'd331, 0, s, lat, bs, br);
      n_checks++;
      if (s != "00000000513") $display("FAIL oct32_331: got \"%s\" want \"00000000513\"", s);
      else n_pass++;
      send(2'd3, 1'b0, 1'b1, 32'd120, 0, s, lat, bs, br);
      n_checks++;
      if (s != "00000078") $display("FAIL hex32_120: got \"%s\" want \"00000078\"", s);
      else n_pass++;
      send(2'd2, 1'b0, 1'b1, 32'd97, 0, s, lat, bs, br);
      n_checks++;
      if (s != "        97") $display("FAIL dec32_97: got \"%s\" want \"        97\"", s);
      else n_pass++;
      send(2'd2, 1'b1, 1'b1, 32'hFFFF_FFF4, 0, s, lat, bs, br);
      n_checks++;
      if (s != "        -12") $display("FAIL dec32_m12: got \"%s\" want \"        -12\"", s);
      else n_pass++;
      send(2'd2, 1'b1, 1'b0, 32'd42, 0, s, lat, bs, br);
      n_checks++;
      if (s != "42") $display("FAIL dec32_42_min: got \"%s\" want \"42\"", s);
      else n_pass++;
   endtask

   task automatic test_dec8;
      string s; int lat; bit bs, br;
      sel8 = 1'b1;
      send(2'd2, 1'b1, 1'b1, 32'h80, 0, s, lat, bs, br);
      n_checks++;
      if (s != "-128") $display("FAIL dec8_m128_pad: got \"%s\" want \"-128\"", s);
      else n_pass++;
      send(2'd2, 1'b1, 1'b1, 32'd5, 0, s, lat, bs, br);
      n_checks++;
      if (s != "   5") $display("FAIL dec8_5_pad: got \"%s\" want \"   5\"", s);
      else n_pass++;
      send(2'd2, 1'b1, 1'b1, 32'd127, 0, s, lat, bs, br);
      n_checks++;
      if (s != " 127") $display("FAIL dec8_127_pad: got \"%s\" want \" 127\"", s);
      else n_pass++;
      send(2'd2, 1'b0, 1'b1, 32'd200, 0, s, lat, bs, br);
      n_checks++;
      if (s != "200") $display("FAIL dec8_200_unsigned: got \"%s\" want \"200\"", s);
      else n_pass++;
      send(2'd2, 1'b1, 1'b0, 32'h80, 0, s, lat, bs, br);
      n_checks++;
      if (s != "-128") $display("FAIL dec8_m128_min: got \"%s\" want \"-128\"", s);
      else n_pass++;
      send(2'd2, 1'b1, 1'b0, 32'd0, 0, s, lat, bs, br);
      n_checks++;
      if (s != "0") $display("FAIL dec8_0_min: got \"%s\" want \"0\"", s);
      else n_pass++;
   endtask

   task automatic test_backpressure;
      string s; int lat; bit bs, br;
      sel8 = 1'b0;
      send(2'd3, 1'b0, 1'b0, 32'h0000_BEEF, 2, s, lat, bs, br);
      n_checks++;
      if (s != "beef") $display("FAIL bp_beef: got \"%s\" want \"beef\"", s);
      else n_pass++;
      n_checks++;
      if (bs) $display("FAIL bp_stable: got changing char/last under stall want stable");
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b0) $display("FAIL bp_no_extra: got valid=%b want 0", o_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      string s; int lat; bit bs, br;
      sel8 = 1'b0;
      @(negedge clk);
      in_mode = 2'd2; in_signed = 1'b0; in_pad = 1'b1; in_value = 32'd4000000000;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 60 && o_valid !== 1'b1; i++) @(negedge clk);
      n_checks++;
      if (o_valid !== 1'b1) $display("FAIL rstmid_reach_emit: got valid=%b want 1", o_valid);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (o_valid !== 1'b0 || o_last !== 1'b0 || o_char !== 8'h00)
         $display("FAIL rstmid_async_drop: valid=%b last=%b char=%h want 0/0/00",
                  o_valid, o_last, o_char);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0)
         $display("FAIL rstmid_idle: ready=%b valid=%b want 1/0", o_ready, o_valid);
      else n_pass++;
      send(2'd2, 1'b1, 1'b1, 32'h8000_0000, 0, s, lat, bs, br);
      n_checks++;
      if (s != "-2147483648") $display("FAIL rstmid_new: got \"%s\" want \"-2147483648\"", s);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      string s1, s2; int lat; bit bs, br1, br2;
      sel8 = 1'b0;
      send(2'd0, 1'b0, 1'b0, 32'd5, 0, s1, lat, bs, br1);
      send(2'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, s2, lat, bs, br2);
      n_checks++;
      if (s1 != "101" || s2 != "ffffffff")
         $display("FAIL b2b_strings: got \"%s\",\"%s\" want \"101\",\"ffffffff\"", s1, s2);
      else n_pass++;
      n_checks++;
      if (br1 || br2) $display("FAIL b2b_in_ready: got in_ready=1 mid-string want 0");
      else n_pass++;
   endtask

   task automatic test_random;
      string s, e; int lat; bit bs, br;
      logic [1:0]  m;
      bit          sg, pd;
      logic [31:0] v;
      sel8 = 1'b0;
      for (int t = 0; t < 32; t++) begin
         m  = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1));
         pd = 1'($urandom_range(0, 1));
         case (t % 8)
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            default: v = $urandom;
         endcase
         e = exp32(m, sg, pd, v);
         send(m, sg, pd, v, 1, s, lat, bs, br);
         n_checks++;
         if (s != e)
            $display("FAIL rand_%0d mode=%0d s=%0d pad=%0d v=%h: got \"%s\" want \"%s\"",
                     t, m, sg, pd, v, s, e);
         else n_pass++;
         n_checks++;
         if (bs) $display("FAIL rand_stable_%0d: got changing char under stall want stable", t);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_bin8();
      test_pad32();
      test_dec8();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
